// File: rtl/seven_seg_mux_counter.sv
// seven_seg_mux_counter: prescaled multi-digit BCD up/down counter driving a
// time-multiplexed seven-segment display with optional leading-zero blanking.
module seven_seg_mux_counter #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000000,
  parameter int REFRESH  = 1024,
  parameter int BLANK    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic              clear,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] digit_sel,
  output logic              wrap
);
  localparam int PW = $clog2(PRESCALE);
  localparam int RW = REFRESH > 1 ? $clog2(REFRESH) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

  logic [PW-1:0]            r_pre;
  logic [RW-1:0]            r_rcnt;
  logic [IW-1:0]            r_idx;
  logic [DIGITS-1:0][3:0]   r_dig;
  logic [6:0]               r_seg;
  logic                     r_dp;
  logic [DIGITS-1:0]        r_sel;
  logic                     r_wrap;
  logic [DIGITS-1:0][3:0]   w_dig_nxt;
  logic [DIGITS-1:0]        w_blank;
  logic [IW-1:0]            w_nidx;
  logic [3:0]               w_d;
  logic                     w_carry;
  logic                     w_z;
  logic                     w_tick;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'h3f;
      4'd1: dec = 7'h06;
      4'd2: dec = 7'h5b;
      4'd3: dec = 7'h4f;
      4'd4: dec = 7'h66;
      4'd5: dec = 7'h6d;
      4'd6: dec = 7'h7d;
      4'd7: dec = 7'h07;
      4'd8: dec = 7'h7f;
      4'd9: dec = 7'h6f;
      default: dec = 7'h00;
    endcase
  endfunction

  assign w_tick = en && r_pre == PW'(PRESCALE - 1);
  assign w_nidx = r_rcnt == RW'(REFRESH - 1) ? (r_idx == IW'(DIGITS - 1) ? '0 : r_idx + 1'b1) : r_idx;

  // Ripple carry/borrow; w_carry surviving past the top digit means a full wrap.
  always_comb begin
    w_dig_nxt = r_dig;
    w_carry = 1'b1;
    w_d = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_d = r_dig[i];
      w_dig_nxt[i] = !w_carry ? w_d : dir ? (w_d == 4'd9 ? 4'd0 : w_d + 4'd1) : (w_d == 4'd0 ? 4'd9 : w_d - 4'd1);
      w_carry = w_carry && (dir ? w_d == 4'd9 : w_d == 4'd0);
    end
  end

  always_comb begin
    w_blank = '0;
    w_z = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_z = w_z && r_dig[i] == 4'd0;
      w_blank[i] = BLANK != 0 && w_z;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pre  <= '0;
      r_dig  <= '0;
      r_wrap <= 1'b0;
    end else if (clear) begin
      r_pre  <= '0;
      r_dig  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_tick && w_carry;
      if (w_tick) begin
        r_pre <= '0;
        r_dig <= w_dig_nxt;
      end else if (en)
        r_pre <= r_pre + 1'b1;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rcnt <= '0;
      r_idx  <= '0;
      r_sel  <= DIGITS'(1);
      r_seg  <= 7'h3f;
      r_dp   <= 1'b0;
    end else begin
      r_rcnt <= r_rcnt == RW'(REFRESH - 1) ? '0 : r_rcnt + 1'b1;
      r_idx  <= w_nidx;
      r_sel  <= DIGITS'(1) << w_nidx;
      r_seg  <= w_blank[w_nidx] ? 7'h00 : dec(r_dig[w_nidx]);
      r_dp   <= w_nidx == '0 && r_pre < PW'(PRESCALE / 2);
    end

  assign seg       = r_seg;
  assign dp        = r_dp;
  assign digit_sel = r_sel;
  assign wrap      = r_wrap;
endmodule
